// File: rtl/line_engine_pkg.sv
// line_engine_pkg: shared FSM encoding and parameter defaults for the line engine
package line_engine_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2
    } state_t;
    localparam logic [9:0] FB_BASE_DEF = 10'h040;
    localparam int         ERR_W_DEF   = 12;
endpackage

// File: rtl/line_setup.sv
// line_setup: orders endpoints and derives Bresenham deltas for one line
//   in : x0, y0, x1, y1   endpoints (10-bit unsigned)
//   out: steep            |dy| > |dx|, so x/y are swapped in sx0/sy0/sx1
//        sx0, sy0, sx1    start point and end x in drawing space, sx0 <= sx1
//        dx, dy           absolute deltas in drawing space
//        ystep_neg        minor axis steps downwards
module line_setup
    import line_engine_pkg::*;
(
    input  logic [9:0]  x0,
    input  logic [9:0]  y0,
    input  logic [9:0]  x1,
    input  logic [9:0]  y1,
    output logic        steep,
    output logic [9:0]  sx0,
    output logic [9:0]  sy0,
    output logic [9:0]  sx1,
    output logic [10:0] dx,
    output logic [10:0] dy,
    output logic        ystep_neg
);
    logic [10:0] adx, ady;
    logic [9:0]  ax0, ay0, ax1, ay1, sy1;
    logic        rev;
    always_comb begin
        adx = (x1 >= x0) ? {1'b0, x1} - {1'b0, x0} : {1'b0, x0} - {1'b0, x1};
        ady = (y1 >= y0) ? {1'b0, y1} - {1'b0, y0} : {1'b0, y0} - {1'b0, y1};
        steep = ady > adx;
        ax0 = steep ? y0 : x0;
        ay0 = steep ? x0 : y0;
        ax1 = steep ? y1 : x1;
        ay1 = steep ? x1 : y1;
        rev = ax0 > ax1;
        sx0 = rev ? ax1 : ax0;
        sy0 = rev ? ay1 : ay0;
        sx1 = rev ? ax0 : ax1;
        sy1 = rev ? ay0 : ay1;
        dx = {1'b0, sx1} - {1'b0, sx0};
        dy = (sy1 >= sy0) ? {1'b0, sy1} - {1'b0, sy0} : {1'b0, sy0} - {1'b0, sy1};
        ystep_neg = sy1 < sy0;
    end
endmodule

// File: rtl/line_engine.sv
// line_engine: Bresenham line rasteriser emitting one framebuffer write per pixel
//   clk, rst (async, active-low)
//   line_color/line_point + *_valid strobes : staging register loads
//   line_trigger / line_ready               : start a draw / engine idle
//   px_addr, px_data, px_valid / px_ready   : pixel write handshake
module line_engine
    import line_engine_pkg::*;
#(
    parameter logic [9:0] FB_BASE = FB_BASE_DEF,
    parameter int         ERR_W   = ERR_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] line_color,
    input  logic [9:0]  line_point,
    input  logic        line_color_valid,
    input  logic        line_x0_valid,
    input  logic        line_y0_valid,
    input  logic        line_x1_valid,
    input  logic        line_y1_valid,
    input  logic        line_trigger,
    output logic        line_ready,
    output logic [31:0] px_addr,
    output logic [31:0] px_data,
    output logic        px_valid,
    input  logic        px_ready
);
    state_t state_q, state_d;
    logic [23:0] color_q, color_d, w_color_q, w_color_d;
    logic [9:0]  x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [9:0]  w_x0_q, w_x0_d, w_y0_q, w_y0_d, w_x1_q, w_x1_d, w_y1_q, w_y1_d;
    logic [9:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d, x_end_q, x_end_d;
    logic [10:0] dx_q, dx_d, dy_q, dy_d;
    logic        steep_q, steep_d, ystep_neg_q, ystep_neg_d;
    logic signed [ERR_W-1:0] err_q, err_d, err_dec, dx_ext, dy_ext;
    logic        s_steep, s_ystep_neg;
    logic [9:0]  s_x0, s_y0, s_x1;
    logic [10:0] s_dx, s_dy;
    logic        unused_color;
    assign unused_color = ^line_color[31:24];

    line_setup u_setup (
        .x0        (w_x0_q),
        .y0        (w_y0_q),
        .x1        (w_x1_q),
        .y1        (w_y1_q),
        .steep     (s_steep),
        .sx0       (s_x0),
        .sy0       (s_y0),
        .sx1       (s_x1),
        .dx        (s_dx),
        .dy        (s_dy),
        .ystep_neg (s_ystep_neg)
    );

    assign line_ready = state_q == IDLE;
    assign px_valid   = state_q == DRAW;
    assign px_addr    = steep_q ? {FB_BASE, cur_x_q, cur_y_q, 2'b00} : {FB_BASE, cur_y_q, cur_x_q, 2'b00};
    assign px_data    = {8'h00, w_color_q};

    always_comb begin
        // the _d staging values double as the bypass path into the snapshot
        color_d = line_color_valid ? line_color[23:0] : color_q;
        x0_d = line_x0_valid ? line_point : x0_q;
        y0_d = line_y0_valid ? line_point : y0_q;
        x1_d = line_x1_valid ? line_point : x1_q;
        y1_d = line_y1_valid ? line_point : y1_q;
        state_d = state_q;
        w_color_d = w_color_q;
        w_x0_d = w_x0_q;
        w_y0_d = w_y0_q;
        w_x1_d = w_x1_q;
        w_y1_d = w_y1_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        x_end_d = x_end_q;
        dx_d = dx_q;
        dy_d = dy_q;
        steep_d = steep_q;
        ystep_neg_d = ystep_neg_q;
        err_d = err_q;
        dx_ext = {{(ERR_W-11){1'b0}}, dx_q};
        dy_ext = {{(ERR_W-11){1'b0}}, dy_q};
        err_dec = err_q - dy_ext;
        case (state_q)
            IDLE: if (line_trigger) begin
                state_d = SETUP;
                w_color_d = color_d;
                w_x0_d = x0_d;
                w_y0_d = y0_d;
                w_x1_d = x1_d;
                w_y1_d = y1_d;
            end
            SETUP: begin
                state_d = DRAW;
                steep_d = s_steep;
                cur_x_d = s_x0;
                cur_y_d = s_y0;
                x_end_d = s_x1;
                dx_d = s_dx;
                dy_d = s_dy;
                ystep_neg_d = s_ystep_neg;
                err_d = {{(ERR_W-10){1'b0}}, s_dx[10:1]};
            end
            DRAW: if (px_ready) begin
                if (cur_x_q == x_end_q) begin
                    state_d = IDLE;
                end else begin
                    cur_x_d = cur_x_q + 10'd1;
                    err_d = err_dec;
                    if (err_dec < 0) begin
                        cur_y_d = ystep_neg_q ? cur_y_q - 10'd1 : cur_y_q + 10'd1;
                        err_d = err_dec + dx_ext;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            color_q <= '0;
            x0_q <= '0;
            y0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            w_color_q <= '0;
            w_x0_q <= '0;
            w_y0_q <= '0;
            w_x1_q <= '0;
            w_y1_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            x_end_q <= '0;
            dx_q <= '0;
            dy_q <= '0;
            steep_q <= 1'b0;
            ystep_neg_q <= 1'b0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            color_q <= color_d;
            x0_q <= x0_d;
            y0_q <= y0_d;
            x1_q <= x1_d;
            y1_q <= y1_d;
            w_color_q <= w_color_d;
            w_x0_q <= w_x0_d;
            w_y0_q <= w_y0_d;
            w_x1_q <= w_x1_d;
            w_y1_q <= w_y1_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            x_end_q <= x_end_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            steep_q <= steep_d;
            ystep_neg_q <= ystep_neg_d;
            err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_line_engine.sv
// tb_line_engine: directed-vector bench for line_engine
module tb_line_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] line_color = '0;
    logic [9:0]  line_point = '0;
    logic        line_color_valid = 1'b0;
    logic        line_x0_valid = 1'b0;
    logic        line_y0_valid = 1'b0;
    logic        line_x1_valid = 1'b0;
    logic        line_y1_valid = 1'b0;
    logic        line_trigger = 1'b0;
    logic        line_ready;
    logic [31:0] px_addr;
    logic [31:0] px_data;
    logic        px_valid;
    logic        px_ready = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    int exp_x[$];
    int exp_y[$];

    always #5 clk = ~clk;

    line_engine dut (
        .clk              (clk),
        .rst              (rst),
        .line_color       (line_color),
        .line_point       (line_point),
        .line_color_valid (line_color_valid),
        .line_x0_valid    (line_x0_valid),
        .line_y0_valid    (line_y0_valid),
        .line_x1_valid    (line_x1_valid),
        .line_y1_valid    (line_y1_valid),
        .line_trigger     (line_trigger),
        .line_ready       (line_ready),
        .px_addr          (px_addr),
        .px_data          (px_data),
        .px_valid         (px_valid),
        .px_ready         (px_ready)
    );

    function automatic logic [31:0] pa(input int x, input int y);
        return {10'h040, y[9:0], x[9:0], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [9:0] x0, y0, x1, y1, input logic [31:0] c);
        line_point = x0; line_x0_valid = 1'b1; @(negedge clk); line_x0_valid = 1'b0;
        line_point = y0; line_y0_valid = 1'b1; @(negedge clk); line_y0_valid = 1'b0;
        line_point = x1; line_x1_valid = 1'b1; @(negedge clk); line_x1_valid = 1'b0;
        line_point = y1; line_y1_valid = 1'b1; @(negedge clk); line_y1_valid = 1'b0;
        line_color = c; line_color_valid = 1'b1; @(negedge clk); line_color_valid = 1'b0;
    endtask

    // expects exp_x/exp_y to hold the n pixels in emission order
    task automatic draw(input int n, input int stall_at, input bit byp, input logic [9:0] byp_v,
                        input logic [23:0] col);
        line_trigger = 1'b1;
        if (byp) begin
            line_point = byp_v;
            line_x0_valid = 1'b1;
        end
        @(negedge clk);
        line_trigger = 1'b0;
        line_x0_valid = 1'b0;
        chk("setup_ready", {31'd0, line_ready}, 32'd0);
        chk("setup_valid", {31'd0, px_valid}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk("px_valid", {31'd0, px_valid}, 32'd1);
            chk("px_addr", px_addr, pa(exp_x[i], exp_y[i]));
            chk("px_data", px_data, {8'h00, col});
            chk("busy", {31'd0, line_ready}, 32'd0);
            if (i == stall_at) begin
                px_ready = 1'b0;
                line_trigger = 1'b1;
                line_point = 10'd0;
                line_x1_valid = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    line_trigger = 1'b0;
                    line_x1_valid = 1'b0;
                    chk("stall_valid", {31'd0, px_valid}, 32'd1);
                    chk("stall_addr", px_addr, pa(exp_x[i], exp_y[i]));
                    chk("stall_data", px_data, {8'h00, col});
                end
                px_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_ready", {31'd0, line_ready}, 32'd1);
        chk("done_valid", {31'd0, px_valid}, 32'd0);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, line_ready}, 32'd1);
        chk("rst_valid", {31'd0, px_valid}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, line_ready}, 32'd1);
        chk("post_rst_valid", {31'd0, px_valid}, 32'd0);

        // horizontal line, upper color bits must be dropped
        load(10'd0, 10'd0, 10'd3, 10'd0, 32'hAA00FF00);
        exp_x = '{0, 1, 2, 3}; exp_y = '{0, 0, 0, 0};
        draw(4, -1, 1'b0, 10'd0, 24'h00FF00);

        // steep line
        load(10'd2, 10'd1, 10'd3, 10'd5, 32'h00123456);
        exp_x = '{2, 2, 2, 3, 3}; exp_y = '{1, 2, 3, 4, 5};
        draw(5, -1, 1'b0, 10'd0, 24'h123456);

        // reversed endpoints
        load(10'd3, 10'd0, 10'd0, 10'd0, 32'h00654321);
        exp_x = '{0, 1, 2, 3}; exp_y = '{0, 0, 0, 0};
        draw(4, -1, 1'b0, 10'd0, 24'h654321);

        // degenerate point
        load(10'd7, 10'd7, 10'd7, 10'd7, 32'h00ABCDEF);
        exp_x = '{7}; exp_y = '{7};
        draw(1, -1, 1'b0, 10'd0, 24'hABCDEF);
        chk("pt_addr_const", pa(7, 7), 32'h1000701C);

        // shallow line with a 5-cycle stall, ignored trigger and busy x1 load
        load(10'd0, 10'd0, 10'd5, 10'd2, 32'h00C0FFEE);
        exp_x = '{0, 1, 2, 3, 4, 5}; exp_y = '{0, 0, 1, 1, 2, 2};
        draw(6, 2, 1'b0, 10'd0, 24'hC0FFEE);
        @(negedge clk);
        chk("no_requeue_valid", {31'd0, px_valid}, 32'd0);
        chk("no_requeue_ready", {31'd0, line_ready}, 32'd1);

        // reset in the middle of a draw
        load(10'd0, 10'd0, 10'd3, 10'd0, 32'h00111111);
        line_trigger = 1'b1;
        @(negedge clk);
        line_trigger = 1'b0;
        @(negedge clk);
        chk("pre_rst_addr0", px_addr, 32'h10000000);
        @(negedge clk);
        chk("pre_rst_addr1", px_addr, 32'h10000004);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, px_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, line_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'd0, line_ready}, 32'd1);
        chk("rel_valid", {31'd0, px_valid}, 32'd0);

        // staging cleared by reset: draws a single black pixel at origin
        exp_x = '{0}; exp_y = '{0};
        draw(1, -1, 1'b0, 10'd0, 24'h000000);

        load(10'd7, 10'd7, 10'd7, 10'd7, 32'h00ABCDEF);
        exp_x = '{7}; exp_y = '{7};
        draw(1, -1, 1'b0, 10'd0, 24'hABCDEF);

        // x0 strobe coincident with trigger is used by that draw
        load(10'd1, 10'd0, 10'd5, 10'd0, 32'h00112233);
        exp_x = '{5}; exp_y = '{0};
        draw(1, -1, 1'b1, 10'd5, 24'h112233);
        chk("byp_addr_const", pa(5, 0), 32'h10000014);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
